hazard_ctrl: RTL and testbench

//  Pipeline hazard controller and the consumer of the ID/EX register's outputs.
//  - Compares ID/EX load info with IF/ID source fields; stalls the front end on a load-use hazard.
//  - Flushes wrong-path instructions on a taken branch resolved in EX/MEM.
//  - Freezes the whole pipe while data memory is busy.
//  - Keeps saturating stall/flush counters for performance debug.

---
 rtl/pipe_ctrl_pkg.sv | 40 ++++
 rtl/hazard_ctrl_sat_counter.sv | 22 ++
 rtl/hazard_ctrl.sv | 130 +++++++++++++
 tb/tb_hazard_ctrl.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared pipeline-control definitions.
//  - state_e     : hazard controller FSM states
//  - REG_ZERO    : hard-wired zero register number ($0 never creates a hazard)
//  - CTL_*       : ID/EX control-field bit positions cleared by bubble/flush
//  - ctl_kill()  : clears a control bundle when a bubble/flush is requested
//  - load_use()  : load-use hazard compare between ID/EX and IF/ID
package pipe_ctrl_pkg;

   typedef enum logic [0:0] {
      RUN      = 1'b0,
      LD_STALL = 1'b1
   } state_e;

   localparam logic [4:0] REG_ZERO = 5'd0;

   // ID/EX control-field layout
   localparam int CTL_REGWRITE = 0;
   localparam int CTL_MEMTOREG = 1;
   localparam int CTL_MEMREAD  = 2;
   localparam int CTL_MEMWRITE = 3;
   localparam int CTL_BRANCH   = 4;
   localparam int CTL_W        = 5;

   function automatic logic [CTL_W-1:0] ctl_kill(input logic [CTL_W-1:0] ctl,
                                                 input logic             kill);
      return kill ? '0 : ctl;
   endfunction

   // rt is only compared when the IF/ID instruction actually reads it
   // (R-type, beq, sw); otherwise an I-type dest field would false-stall.
   function automatic logic load_use(input logic       memread,
                                     input logic [4:0] ld_rt,
                                     input logic [4:0] rs,
                                     input logic [4:0] rt,
                                     input logic       uses_rt);
      return memread && (ld_rt != REG_ZERO) &&
             ((ld_rt == rs) || (uses_rt && (ld_rt == rt)));
   endfunction

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear.
//  clk  in   clock
//  inc  in   count one event this cycle
//  clr  in   clear to zero (beats inc)
//  cnt  out  current count, sticks at all-ones
module sat_counter #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             inc,
   input  logic             clr,
   output logic [CNT_W-1:0] cnt
);

   always_ff @(posedge clk) begin
      if (clr)
         cnt <= '0;
      else if (inc && (cnt != {CNT_W{1'b1}}))
         cnt <= cnt + 1'b1;
   end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, taken-branch flush, memory-busy
// freeze, plus saturating stall/flush counters for performance debug.
//  clk_i, rst_i              clock, synchronous active-high reset
//  idex_memread_i/rtaddr_i   load info from ID/EX
//  ifid_rs_i/rt_i/uses_rt_i  source fields of the instruction in IF/ID
//  branch_taken_i            taken branch resolved in EX/MEM
//  mem_busy_i                data memory not ready
//  clear_cnt_i               clear both counters
//  pc_write_o, ifid_write_o  front-end load enables
//  idex_bubble_o             zero ID/EX control (load-use bubble)
//  ifid_flush_o, idex_flush_o, pc_src_o  wrong-path flush / branch redirect
//  pipe_freeze_o             hold ID/EX, EX/MEM, MEM/WB
//  stall_cnt_o, flush_cnt_o  saturating event counters
// Control outputs are combinational from state + inputs; counters update on
// the next clock edge.
module hazard_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int LOAD_STALL_CYCLES = 1,
   parameter int CNT_W             = 16
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             idex_memread_i,
   input  logic [4:0]       idex_rtaddr_i,
   input  logic [4:0]       ifid_rs_i,
   input  logic [4:0]       ifid_rt_i,
   input  logic             ifid_uses_rt_i,
   input  logic             branch_taken_i,
   input  logic             mem_busy_i,
   input  logic             clear_cnt_i,
   output logic             pc_write_o,
   output logic             ifid_write_o,
   output logic             idex_bubble_o,
   output logic             ifid_flush_o,
   output logic             idex_flush_o,
   output logic             pc_src_o,
   output logic             pipe_freeze_o,
   output logic [CNT_W-1:0] stall_cnt_o,
   output logic [CNT_W-1:0] flush_cnt_o
);

   localparam int              LU_W    = (LOAD_STALL_CYCLES > 1) ? $clog2(LOAD_STALL_CYCLES) : 1;
   localparam logic [LU_W-1:0] LU_INIT = LU_W'(LOAD_STALL_CYCLES - 1);

   state_e          state, state_nxt;
   logic [LU_W-1:0] lu_cnt, lu_nxt;
   logic            hazard, stall_inc, flush_inc;

   assign hazard = load_use(idex_memread_i, idex_rtaddr_i, ifid_rs_i,
                            ifid_rt_i, ifid_uses_rt_i);

   always_comb begin
      pc_write_o    = 1'b1;
      ifid_write_o  = 1'b1;
      idex_bubble_o = 1'b0;
      ifid_flush_o  = 1'b0;
      idex_flush_o  = 1'b0;
      pc_src_o      = 1'b0;
      pipe_freeze_o = 1'b0;
      stall_inc     = 1'b0;
      flush_inc     = 1'b0;
      state_nxt     = state;
      lu_nxt        = lu_cnt;
      if (rst_i) begin
         pc_write_o    = 1'b0;
         ifid_write_o  = 1'b0;
         idex_bubble_o = 1'b1;
      end else if (mem_busy_i) begin
         // Everything holds, including a pending branch in EX/MEM.
         pipe_freeze_o = 1'b1;
         pc_write_o    = 1'b0;
         ifid_write_o  = 1'b0;
         stall_inc     = 1'b1;
      end else if (branch_taken_i) begin
         // A stalled instruction behind a taken branch is wrong-path: drop it.
         pc_src_o     = 1'b1;
         ifid_flush_o = 1'b1;
         idex_flush_o = 1'b1;
         flush_inc    = 1'b1;
         state_nxt    = RUN;
         lu_nxt       = '0;
      end else if (state == LD_STALL) begin
         pc_write_o    = 1'b0;
         ifid_write_o  = 1'b0;
         idex_bubble_o = 1'b1;
         stall_inc     = 1'b1;
         lu_nxt        = lu_cnt - 1'b1;
         if (lu_cnt <= LU_W'(1)) begin
            state_nxt = RUN;
            lu_nxt    = '0;
         end
      end else if (hazard) begin
         pc_write_o    = 1'b0;
         ifid_write_o  = 1'b0;
         idex_bubble_o = 1'b1;
         stall_inc     = 1'b1;
         // First bubble is this cycle; LD_STALL covers the remaining ones.
         if (LOAD_STALL_CYCLES > 1) begin
            state_nxt = LD_STALL;
            lu_nxt    = LU_INIT;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state  <= RUN;
         lu_cnt <= '0;
      end else begin
         state  <= state_nxt;
         lu_cnt <= lu_nxt;
      end
   end

   sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
      .clk (clk_i),
      .inc (stall_inc),
      .clr (rst_i | clear_cnt_i),
      .cnt (stall_cnt_o)
   );

   sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
      .clk (clk_i),
      .inc (flush_inc),
      .clr (rst_i | clear_cnt_i),
      .cnt (flush_cnt_o)
   );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench: three instances sharing stimulus.
//  d0: LOAD_STALL_CYCLES=1, CNT_W=16
//  d1: LOAD_STALL_CYCLES=3, CNT_W=16
//  d2: LOAD_STALL_CYCLES=1, CNT_W=4 (saturation)
// Inputs change 1ns after posedge; combinational outputs are sampled on
// negedge, counters after the following posedge.
module tb_hazard_ctrl;

   logic       clk = 1'b0;
   logic       rst, memread, uses_rt, branch, busy, clr;
   logic [4:0] ld_rt, rs, rt;

   logic        pc_write[3], ifid_write[3], bubble[3], ifid_flush[3];
   logic        idex_flush[3], pc_src[3], freeze[3];
   logic [15:0] stall_cnt[2], flush_cnt[2];
   logic [3:0]  stall_cnt4, flush_cnt4;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   hazard_ctrl #(.LOAD_STALL_CYCLES(1), .CNT_W(16)) u_d0 (
      .clk_i(clk), .rst_i(rst), .idex_memread_i(memread), .idex_rtaddr_i(ld_rt),
      .ifid_rs_i(rs), .ifid_rt_i(rt), .ifid_uses_rt_i(uses_rt),
      .branch_taken_i(branch), .mem_busy_i(busy), .clear_cnt_i(clr),
      .pc_write_o(pc_write[0]), .ifid_write_o(ifid_write[0]), .idex_bubble_o(bubble[0]),
      .ifid_flush_o(ifid_flush[0]), .idex_flush_o(idex_flush[0]), .pc_src_o(pc_src[0]),
      .pipe_freeze_o(freeze[0]), .stall_cnt_o(stall_cnt[0]), .flush_cnt_o(flush_cnt[0]));

   hazard_ctrl #(.LOAD_STALL_CYCLES(3), .CNT_W(16)) u_d1 (
      .clk_i(clk), .rst_i(rst), .idex_memread_i(memread), .idex_rtaddr_i(ld_rt),
      .ifid_rs_i(rs), .ifid_rt_i(rt), .ifid_uses_rt_i(uses_rt),
      .branch_taken_i(branch), .mem_busy_i(busy), .clear_cnt_i(clr),
      .pc_write_o(pc_write[1]), .ifid_write_o(ifid_write[1]), .idex_bubble_o(bubble[1]),
      .ifid_flush_o(ifid_flush[1]), .idex_flush_o(idex_flush[1]), .pc_src_o(pc_src[1]),
      .pipe_freeze_o(freeze[1]), .stall_cnt_o(stall_cnt[1]), .flush_cnt_o(flush_cnt[1]));

   hazard_ctrl #(.LOAD_STALL_CYCLES(1), .CNT_W(4)) u_d2 (
      .clk_i(clk), .rst_i(rst), .idex_memread_i(memread), .idex_rtaddr_i(ld_rt),
      .ifid_rs_i(rs), .ifid_rt_i(rt), .ifid_uses_rt_i(uses_rt),
      .branch_taken_i(branch), .mem_busy_i(busy), .clear_cnt_i(clr),
      .pc_write_o(pc_write[2]), .ifid_write_o(ifid_write[2]), .idex_bubble_o(bubble[2]),
      .ifid_flush_o(ifid_flush[2]), .idex_flush_o(idex_flush[2]), .pc_src_o(pc_src[2]),
      .pipe_freeze_o(freeze[2]), .stall_cnt_o(stall_cnt4), .flush_cnt_o(flush_cnt4));

   task automatic idle_inputs();
      memread = 0; uses_rt = 0; branch = 0; busy = 0; clr = 0;
      ld_rt = 0; rs = 0; rt = 0;
   endtask

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst = 1; tick(); rst = 0;
   endtask

   task automatic test_reset();
      idle_inputs();
      rst = 1; memread = 1; ld_rt = 5'd8; rs = 5'd8; branch = 1;
      @(negedge clk);
      n_cmp++;
      if ({pc_write[0], ifid_write[0], bubble[0]} !== 3'b001) begin
         n_bad++; $display("FAIL reset_ctl: got %b want 001", {pc_write[0], ifid_write[0], bubble[0]});
      end
      n_cmp++;
      if ({ifid_flush[0], idex_flush[0], pc_src[0], freeze[0]} !== 4'b0000) begin
         n_bad++; $display("FAIL reset_flush: got %b want 0000", {ifid_flush[0], idex_flush[0], pc_src[0], freeze[0]});
      end
      tick();
      n_cmp++;
      if (stall_cnt[0] !== 16'd0 || flush_cnt[0] !== 16'd0) begin
         n_bad++; $display("FAIL reset_cnt: got %0d/%0d want 0/0", stall_cnt[0], flush_cnt[0]);
      end
      rst = 0; idle_inputs();
   endtask

   task automatic test_load_use();
      do_reset();
      memread = 1; ld_rt = 5'd8; rs = 5'd8;
      @(negedge clk);
      n_cmp++;
      if ({pc_write[0], ifid_write[0], bubble[0]} !== 3'b001) begin
         n_bad++; $display("FAIL load_use_stall: got %b want 001", {pc_write[0], ifid_write[0], bubble[0]});
      end
      tick(); memread = 0;
      @(negedge clk);
      n_cmp++;
      if ({pc_write[0], bubble[0]} !== 2'b10) begin
         n_bad++; $display("FAIL load_use_release: got %b want 10", {pc_write[0], bubble[0]});
      end
      n_cmp++;
      if (stall_cnt[0] !== 16'd1) begin
         n_bad++; $display("FAIL load_use_cnt: got %0d want 1", stall_cnt[0]);
      end
   endtask

   task automatic test_multi_stall();
      // LOAD_STALL_CYCLES=3: three stall cycles even though the hazard is one cycle.
      do_reset();
      memread = 1; ld_rt = 5'd12; rs = 5'd12;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         n_cmp++;
         if (pc_write[1] !== (i == 3)) begin
            n_bad++; $display("FAIL multi_stall_c%0d: pc_write got %b want %b", i, pc_write[1], (i == 3));
         end
         tick(); memread = 0;
      end
      n_cmp++;
      if (stall_cnt[1] !== 16'd3) begin
         n_bad++; $display("FAIL multi_stall_cnt: got %0d want 3", stall_cnt[1]);
      end
   endtask

   task automatic test_zero_reg();
      do_reset();
      memread = 1; ld_rt = 5'd0; rs = 5'd0;
      @(negedge clk);
      n_cmp++;
      if ({pc_write[0], bubble[0]} !== 2'b10) begin
         n_bad++; $display("FAIL zero_reg: got %b want 10", {pc_write[0], bubble[0]});
      end
      tick();
      n_cmp++;
      if (stall_cnt[0] !== 16'd0) begin
         n_bad++; $display("FAIL zero_reg_cnt: got %0d want 0", stall_cnt[0]);
      end
   endtask

   task automatic test_rt_gate();
      do_reset();
      memread = 1; ld_rt = 5'd9; rt = 5'd9; rs = 5'd3; uses_rt = 0;
      @(negedge clk);
      n_cmp++;
      if (pc_write[0] !== 1'b1) begin
         n_bad++; $display("FAIL rt_gate_off: pc_write got %b want 1", pc_write[0]);
      end
      uses_rt = 1;
      #1;
      n_cmp++;
      if ({pc_write[0], ifid_write[0], bubble[0]} !== 3'b001) begin
         n_bad++; $display("FAIL rt_gate_on: got %b want 001", {pc_write[0], ifid_write[0], bubble[0]});
      end
   endtask

   task automatic test_branch_in_stall();
      do_reset();
      memread = 1; ld_rt = 5'd8; rs = 5'd8;
      tick();
      memread = 0; branch = 1;           // 2nd stall cycle of d1
      @(negedge clk);
      n_cmp++;
      if ({pc_src[1], ifid_flush[1], idex_flush[1], pc_write[1]} !== 4'b1111) begin
         n_bad++; $display("FAIL branch_flush: got %b want 1111", {pc_src[1], ifid_flush[1], idex_flush[1], pc_write[1]});
      end
      tick(); branch = 0;
      @(negedge clk);
      n_cmp++;
      if ({pc_write[1], bubble[1]} !== 2'b10) begin
         n_bad++; $display("FAIL branch_run: got %b want 10", {pc_write[1], bubble[1]});
      end
      n_cmp++;
      if (flush_cnt[1] !== 16'd1 || stall_cnt[1] !== 16'd1) begin
         n_bad++; $display("FAIL branch_cnt: got %0d/%0d want 1/1", flush_cnt[1], stall_cnt[1]);
      end
   endtask

   task automatic test_mem_busy();
      do_reset();
      busy = 1; branch = 1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         n_cmp++;
         if ({freeze[0], pc_write[0], pc_src[0], ifid_flush[0]} !== 4'b1000) begin
            n_bad++; $display("FAIL busy_c%0d: got %b want 1000", i, {freeze[0], pc_write[0], pc_src[0], ifid_flush[0]});
         end
         tick();
      end
      busy = 0;
      @(negedge clk);
      n_cmp++;
      if ({freeze[0], pc_src[0], ifid_flush[0], idex_flush[0]} !== 4'b0111) begin
         n_bad++; $display("FAIL busy_then_branch: got %b want 0111", {freeze[0], pc_src[0], ifid_flush[0], idex_flush[0]});
      end
      n_cmp++;
      if (stall_cnt[0] !== 16'd4) begin
         n_bad++; $display("FAIL busy_stall_cnt: got %0d want 4", stall_cnt[0]);
      end
      tick(); branch = 0;
      n_cmp++;
      if (flush_cnt[0] !== 16'd1) begin
         n_bad++; $display("FAIL busy_flush_cnt: got %0d want 1", flush_cnt[0]);
      end
   endtask

   task automatic test_saturation();
      do_reset();
      memread = 1; ld_rt = 5'd4; rs = 5'd4;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (i == 13) begin
            n_cmp++;
            if (stall_cnt4 !== 4'd14) begin
               n_bad++; $display("FAIL sat_c14: got %0d want 14", stall_cnt4);
            end
         end
      end
      n_cmp++;
      if (stall_cnt4 !== 4'd15) begin
         n_bad++; $display("FAIL sat_hold: got %0d want 15", stall_cnt4);
      end
      clr = 1;                            // stall still active this cycle
      tick(); clr = 0; memread = 0;
      n_cmp++;
      if (stall_cnt4 !== 4'd0) begin
         n_bad++; $display("FAIL sat_clear: got %0d want 0", stall_cnt4);
      end
   endtask

   task automatic test_reset_mid_stall();
      do_reset();
      memread = 1; ld_rt = 5'd8; rs = 5'd8;
      tick(); memread = 0;
      @(negedge clk);
      n_cmp++;
      if (pc_write[1] !== 1'b0) begin
         n_bad++; $display("FAIL mid_stall_pre: pc_write got %b want 0", pc_write[1]);
      end
      tick(); rst = 1;
      tick(); rst = 0;
      @(negedge clk);
      n_cmp++;
      if ({pc_write[1], bubble[1]} !== 2'b10) begin
         n_bad++; $display("FAIL mid_stall_run: got %b want 10", {pc_write[1], bubble[1]});
      end
      n_cmp++;
      if (stall_cnt[1] !== 16'd0) begin
         n_bad++; $display("FAIL mid_stall_cnt: got %0d want 0", stall_cnt[1]);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      rst = 1; idle_inputs();
      tick();
      test_reset();
      test_load_use();
      test_multi_stall();
      test_zero_reg();
      test_rt_gate();
      test_branch_in_stall();
      test_mem_busy();
      test_saturation();
      test_reset_mid_stall();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
